// File: rtl/pointing_device_pkg.sv
// Shared definitions for the CD-i pointing-device receiver.
// Holds the receive FSM state type, byte-class markers, the known device ID
// byte, and the frame field positions, which the transmitter-side model also uses.
// A frame is header, X byte, Y byte. The header carries two button bits and
// the top two bits of dx and dy. The X and Y bytes carry the low six bits.
package pointing_device_pkg;

  typedef enum logic [2:0] {
    ST_RTS_HOLD = 3'd0,
    ST_WAIT_ID  = 3'd1,
    ST_IDLE     = 3'd2,
    ST_GOT0     = 3'd3,
    ST_GOT1     = 3'd4
  } e_rx_state;

  localparam logic [1:0] kHeaderMarker  = 2'b11;
  localparam logic [1:0] kDataMarker    = 2'b10;
  localparam logic [7:0] kDeviceIdSpoon = 8'hCA;

  // Frame field positions
  localparam int kMarkerLsb   = 6;
  localparam int kPayloadBits = 6;
  localparam int kHdrDxLsb    = 0;
  localparam int kHdrDyLsb    = 2;
  localparam int kHdrB2Bit    = 4;
  localparam int kHdrB1Bit    = 5;

  function automatic logic [7:0] frame_dx(input logic [5:0] hdr, input logic [5:0] xb);
    return {hdr[kHdrDxLsb+1:kHdrDxLsb], xb[kPayloadBits-1:0]};
  endfunction

  function automatic logic [7:0] frame_dy(input logic [5:0] hdr, input logic [5:0] yb);
    return {hdr[kHdrDyLsb+1:kHdrDyLsb], yb[kPayloadBits-1:0]};
  endfunction

endpackage

// File: rtl/pointer_axis_accumulator.sv
// One cursor axis: adds a signed 8-bit delta on apply and clamps to 0..MAX.
// Ports:
//   clk, reset_n : clock, async active-low reset (position -> MAX>>1)
//   apply        : add delta this cycle
//   delta[7:0]   : signed motion
//   position     : current clamped position
module pointer_axis_accumulator #(
  parameter int MAX   = 383,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             apply,
  input  logic [7:0]       delta,
  output logic [WIDTH-1:0] position
);

  localparam logic [WIDTH-1:0] kResetPos = WIDTH'(MAX >> 1);
  localparam logic [WIDTH-1:0] kMaxPos   = WIDTH'(MAX);
  localparam logic signed [11:0] kMaxS   = 12'(MAX);

  logic [WIDTH-1:0]   r_pos;
  logic signed [11:0] w_sum;
  logic [WIDTH-1:0]   w_next;

  // 12 bits hold any position plus or minus 128 without wrapping.
  assign w_sum = $signed({{(12-WIDTH){1'b0}}, r_pos}) + $signed({{4{delta[7]}}, delta});

  always_comb begin
    w_next = w_sum[WIDTH-1:0];
    if (w_sum < 12'sd0) begin
      w_next = '0;
    end else if (w_sum > kMaxS) begin
      w_next = kMaxPos;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pos <= kResetPos;
    end else if (apply) begin
      r_pos <= w_next;
    end
  end

  assign position = r_pos;

endmodule

// File: rtl/pointing_device_receiver.sv
// Host-side CD-i pointing-device decoder.
// It forces device identification with RTS, captures the ID byte, and parses
// 3-byte motion frames into a clamped absolute cursor and button state.
// Ports:
//   clk, reset_n                     : clock, async active-low reset
//   reidentify                       : one-cycle request to restart identification
//   serial_in_data, serial_in_write  : received UART byte and its valid strobe
//   rts                              : request-to-send to the device
//   device_id, id_valid              : captured ID byte, and a flag that the ID is valid
//   x_pos, y_pos, b1, b2             : cursor position and button state
//   update                           : one-cycle pulse when a frame is applied
//   error_count                      : saturating protocol error counter
//
// state       | meaning
// ------------+----------------------------------------------------
// ST_RTS_HOLD | rts high, bytes ignored, hold counter running
// ST_WAIT_ID  | next byte is the device ID
// ST_IDLE     | waiting for a frame header
// ST_GOT0     | header held, waiting for the X byte (timeout armed)
// ST_GOT1     | X byte held, waiting for the Y byte (timeout armed)
module pointing_device_receiver
  import pointing_device_pkg::*;
#(
  parameter int X_MAX         = 383,
  parameter int Y_MAX         = 279,
  parameter int RTS_TICKS     = 30000,
  parameter int TIMEOUT_TICKS = 750000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       reidentify,
  input  logic [7:0] serial_in_data,
  input  logic       serial_in_write,
  output logic       rts,
  output logic [7:0] device_id,
  output logic       id_valid,
  output logic [9:0] x_pos,
  output logic [8:0] y_pos,
  output logic       b1,
  output logic       b2,
  output logic       update,
  output logic [7:0] error_count
);

  localparam int RW = $clog2(RTS_TICKS + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  e_rx_state r_state, w_next_state;

  logic [RW-1:0] r_rts_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [5:0]    r_hdr;
  logic [5:0]    r_xb;
  logic [7:0]    r_device_id;
  logic          r_id_valid;
  logic          r_apply;
  logic [7:0]    r_dx;
  logic [7:0]    r_dy;
  logic [1:0]    r_btn_stage;
  logic          r_b1;
  logic          r_b2;
  logic          r_update;
  logic [7:0]    r_err_cnt;

  logic w_is_hdr, w_is_data, w_timeout, w_rts_done;
  logic w_err, w_store_hdr, w_store_x, w_store_id, w_frame_done;

  assign w_is_hdr   = serial_in_data[kMarkerLsb+1:kMarkerLsb] == kHeaderMarker;
  assign w_is_data  = serial_in_data[kMarkerLsb+1:kMarkerLsb] == kDataMarker;
  assign w_rts_done = (r_rts_cnt == '0);
  // A byte arriving in the expiry cycle takes precedence over the timeout.
  assign w_timeout  = ((r_state == ST_GOT0) || (r_state == ST_GOT1)) &&
                      !serial_in_write && (r_to_cnt == '0);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RTS_HOLD;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and datapath strobes
  always_comb begin
    w_next_state = r_state;
    w_err        = 1'b0;
    w_store_hdr  = 1'b0;
    w_store_x    = 1'b0;
    w_store_id   = 1'b0;
    w_frame_done = 1'b0;
    if (reidentify) begin
      w_next_state = ST_RTS_HOLD;
    end else begin
      case (r_state)
        ST_RTS_HOLD: begin
          if (w_rts_done) w_next_state = ST_WAIT_ID;
        end
        ST_WAIT_ID: begin
          if (serial_in_write) begin
            w_store_id   = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (serial_in_write) begin
            if (w_is_hdr) begin
              w_store_hdr  = 1'b1;
              w_next_state = ST_GOT0;
            end else begin
              w_err = 1'b1;
            end
          end
        end
        ST_GOT0: begin
          if (serial_in_write) begin
            if (w_is_data) begin
              w_store_x    = 1'b1;
              w_next_state = ST_GOT1;
            end else if (w_is_hdr) begin
              w_err       = 1'b1;
              w_store_hdr = 1'b1;
            end else begin
              w_err        = 1'b1;
              w_next_state = ST_IDLE;
            end
          end else if (w_timeout) begin
            w_err        = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
        ST_GOT1: begin
          if (serial_in_write) begin
            if (w_is_data) begin
              w_frame_done = 1'b1;
              w_next_state = ST_IDLE;
            end else if (w_is_hdr) begin
              w_err        = 1'b1;
              w_store_hdr  = 1'b1;
              w_next_state = ST_GOT0;
            end else begin
              w_err        = 1'b1;
              w_next_state = ST_IDLE;
            end
          end else if (w_timeout) begin
            w_err        = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
        default: w_next_state = ST_RTS_HOLD;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    rts = 1'b0;
    if (r_state == ST_RTS_HOLD) rts = 1'b1;
  end

  // RTS hold and inter-byte timers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rts_cnt <= RW'(RTS_TICKS - 1);
      r_to_cnt  <= TW'(TIMEOUT_TICKS);
    end else begin
      if (reidentify) begin
        r_rts_cnt <= RW'(RTS_TICKS - 1);
      end else if ((r_state == ST_RTS_HOLD) && !w_rts_done) begin
        r_rts_cnt <= r_rts_cnt - 1'b1;
      end
      if (serial_in_write) begin
        r_to_cnt <= TW'(TIMEOUT_TICKS);
      end else if (r_to_cnt != '0) begin
        r_to_cnt <= r_to_cnt - 1'b1;
      end
    end
  end

  // Frame capture. A completed frame is staged for one cycle so that the
  // position, buttons and update all change together one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hdr       <= '0;
      r_xb        <= '0;
      r_apply     <= 1'b0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_btn_stage <= '0;
      r_b1        <= 1'b0;
      r_b2        <= 1'b0;
      r_update    <= 1'b0;
    end else begin
      if (w_store_hdr) r_hdr <= serial_in_data[5:0];
      if (w_store_x)   r_xb  <= serial_in_data[5:0];
      r_apply <= w_frame_done;
      if (w_frame_done) begin
        r_dx        <= frame_dx(r_hdr, r_xb);
        r_dy        <= frame_dy(r_hdr, serial_in_data[5:0]);
        r_btn_stage <= {r_hdr[kHdrB1Bit], r_hdr[kHdrB2Bit]};
      end
      r_update <= r_apply;
      if (r_apply) begin
        r_b1 <= r_btn_stage[1];
        r_b2 <= r_btn_stage[0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_device_id <= '0;
      r_id_valid  <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      if (reidentify) begin
        r_id_valid <= 1'b0;
      end else if (w_store_id) begin
        r_device_id <= serial_in_data;
        r_id_valid  <= 1'b1;
      end
      if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  pointer_axis_accumulator #(.MAX(X_MAX), .WIDTH(10)) u_acc_x (
    .clk      (clk),
    .reset_n  (reset_n),
    .apply    (r_apply),
    .delta    (r_dx),
    .position (x_pos)
  );

  pointer_axis_accumulator #(.MAX(Y_MAX), .WIDTH(9)) u_acc_y (
    .clk      (clk),
    .reset_n  (reset_n),
    .apply    (r_apply),
    .delta    (r_dy),
    .position (y_pos)
  );

  assign device_id   = r_device_id;
  assign id_valid    = r_id_valid;
  assign b1          = r_b1;
  assign b2          = r_b2;
  assign update      = r_update;
  assign error_count = r_err_cnt;

endmodule

// File: doc/pointing_device_receiver.md
# pointing_device_receiver

Host-side decoder for the CD-i pointing-device serial protocol at 1200 baud. Sits between the UART receive bytestream and the video cursor/IKAT input logic. It drives RTS to force device identification, captures the device ID byte, and parses 3-byte relative-motion frames with sync checking and an inter-byte timeout. It accumulates a clamped absolute cursor position and button state.

## Interface
Parameters:
- `X_MAX`, 383: highest cursor X coordinate; position clamps to 0..X_MAX.
- `Y_MAX`, 279: highest cursor Y coordinate; position clamps to 0..Y_MAX.
- `RTS_TICKS`, 30000: clk cycles RTS is held high per identification request (1 ms at 30 MHz).
- `TIMEOUT_TICKS`, 750000: maximum clk cycles allowed between consecutive bytes of one frame.

Ports:
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `reidentify`, in, 1: single-cycle request to restart the identification sequence.
- `serial_in`, bytestream.sink, -: `data[7:0]` is valid when `write`=1; one byte per pulse; no backpressure.
- `rts`, out, 1: request-to-send to the device.
- `device_id`, out, 8: last captured ID byte.
- `id_valid`, out, 1: set once an ID byte is captured after RTS.
- `x_pos`, out, 10: cursor X position.
- `y_pos`, out, 9: cursor Y position; increases downward.
- `b1`, `b2`, out, 1 each: button state from the last complete frame.
- `update`, out, 1: one-cycle pulse when a frame is applied.
- `error_count`, out, 8: saturating count of protocol errors.

## Operation
States:
- **RTS_HOLD**
  - `rts`=1 and a down-counter runs from RTS_TICKS-1.
  - All input bytes are ignored and are not counted as errors.
  - At count 0: go to WAIT_ID.
- **WAIT_ID**
  - The next byte is stored to `device_id` and sets `id_valid`.
  - Go to IDLE.
- **IDLE**
  - Header byte (`data[7:6]`=11): store it, go to GOT0.
  - Data byte (`data[7:6]`=10) or `data[7:6]`=0x: error, stay in IDLE.
- **GOT0**
  - Data byte: store it as the X byte, go to GOT1.
  - Header byte: error, store it as the new header, stay in GOT0.
  - Any other byte: error, go to IDLE.
- **GOT1**
  - Data byte: the frame is complete. Apply it and go to IDLE.
  - Header byte: error, go to GOT0 with the new header.
  - Any other byte: error, go to IDLE.
- **Timeout:** in GOT0/GOT1, a counter reloads to TIMEOUT_TICKS on every accepted byte. When it reaches 0: error, go to IDLE.

Frame decode:
- dx = signed 8-bit {hdr[1:0], xb[5:0]}.
- dy = signed 8-bit {hdr[3:2], yb[5:0]}.
- b1 = hdr[5], b2 = hdr[4].

Position update:
- Sign-extend to 12 bits, add, then clamp to [0, X_MAX] / [0, Y_MAX].
- A frame with dx=dy=0 still updates the buttons and pulses `update`.

Errors: `error_count` increments by 1 per error and saturates at 255.

## Timing
Reset values:
- State RTS_HOLD, `rts`=1.
- `device_id`=0, `id_valid`=0.
- `x_pos`=X_MAX>>1 (191), `y_pos`=Y_MAX>>1 (139).
- `b1`=`b2`=0, `update`=0, `error_count`=0.

Latency and counters:
- `update`, position and buttons are registered. They change on the clk edge after the edge that samples the third byte's `write`, giving 1 cycle latency.
- `rts` falls exactly RTS_TICKS cycles after leaving reset or after a `reidentify` pulse.

Boundary and simultaneous events:
- `reidentify` has priority over a same-cycle byte; the byte is dropped.
- `reidentify` clears `id_valid`, keeps `device_id`, restarts RTS_HOLD and discards any partial frame.
- `reidentify` during RTS_HOLD restarts the counter.
- Position, buttons and `error_count` are unaffected by `reidentify`.
- A timeout expiring in the same cycle as a byte arrives: the byte wins and the timeout is ignored.
- Clamping at the limits is exact: x=0 with dx=-8 gives 0; x=X_MAX with dx=+8 gives X_MAX.

## Structure
- Package `pointing_device_pkg`:
  - state enum `e_rx_state`
  - byte-class constants `kHeaderMarker`=2'b11, `kDataMarker`=2'b10
  - `kDeviceIdSpoon`=8'hCA
  - frame field positions, shared with the transmitter-side model
- Sub-module `pointer_axis_accumulator`, instantiated twice:
  - parameters: MAX, width
  - inputs: clk, reset_n, apply, delta[7:0]
  - output: position
  - reset value MAX>>1; saturating add/clamp

## Test plan
- Reset release -> `rts`=1 for exactly 30000 cycles, then 0; byte 0xCA -> `device_id`=0xCA, `id_valid`=1.
- After ID, frame 0xC0,0x85,0x83 -> single `update` pulse 1 cycle after the last byte; `x_pos`=196, `y_pos`=142; b1=b2=0.
- Frame 0xCF,0xB8,0xB8 (dx=dy=-8) repeated 30 times from centre -> x and y clamp at 0; no wrap.
- Frame 0xF0,0x80,0x80 -> b1=1, b2=1, position unchanged, `update` pulses.
- Bytes 0xC0,0xC0,0x85,0x83 -> `error_count`=1, then the frame is applied with dx=5, dy=3.
- Bytes 0xC0,0x85, gap of 750001 cycles, then 0x83 -> `error_count`=2 (timeout plus data byte in IDLE), no `update`. Also check: `reidentify` coincident with a byte -> byte dropped, `rts` high 30000 cycles, `id_valid`=0.
